mips_fetch_exec_unit: RTL and testbench
=======================================

MIPS_FETCH_EXEC_UNIT -- requirements
Module: mips_fetch_exec_unit

Parameters
REQ-001 SHALL have IMEM_DEPTH, default 64, meaning number of 32-bit instruction words (power of 2).

Interface
REQ-002 SHALL have clk  in  1  rising-edge clock.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have imem_we  in  1  instruction-memory write enable.
REQ-005 SHALL have imem_waddr  in  log2(IMEM_DEPTH)  word address for a load.
REQ-006 SHALL have imem_wdata  in  32  instruction word to load.
REQ-007 SHALL have rd1  in  32  register-file data for rs (ALU A).
REQ-008 SHALL have rd2  in  32  register-file data for rt.
REQ-009 SHALL have pc  out  32  current PC.
REQ-010 SHALL have instr  out  32  fetched instruction.
REQ-011 SHALL have rs, rt, wreg  out  5 each  as follows: rs=instr[25:21]; rt=instr[20:16]; wreg=RegDst ? instr[15:11] : rt.
REQ-012 SHALL have imm  out  32  sign-extended instr[15:0].
REQ-013 SHALL have reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump  out  1 each  decoded controls.
REQ-014 SHALL have alu_ctl  out  3  ALU operation.
REQ-015 SHALL have alu_result  out  32  ALU output.
REQ-016 SHALL have zf, cf, sf, pf, of  out  1 each  ALU flags.

Function
REQ-017 SHALL hold the instruction memory as a ROM of IMEM_DEPTH x 32 words, combinationally read at word index pc[log2(IMEM_DEPTH)+1:2]; upper PC bits are ignored (address wraps).
REQ-018 SHALL write imem_wdata into word imem_waddr on a rising clk edge when imem_we=1; the write is visible on instr combinationally after that edge, including for the currently addressed word.
REQ-019 SHALL decode (opcode=instr[31:26], funct=instr[5:0]):
- R-type 000000: reg_write=1, reg_dst=1; funct 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111; any other funct: all controls 0, alu_ctl=010.
- lw 100011: reg_write, alu_src, mem_to_reg=1; alu_ctl 010.
- sw 101011: mem_write, alu_src=1; alu_ctl 010.
- beq 000100: branch=1; alu_ctl 110.
- addi 001000: reg_write, alu_src=1; alu_ctl 010.
- j 000010: jump=1; alu_ctl 010.
- Any other opcode: all controls 0, alu_ctl=010.
REQ-020 SHALL compute ALU A=rd1, B=alu_src ? imm : rd2; F per alu_ctl: 000 A&B, 001 A|B, 010 A+B, 110 A-B, 111 signed(A<B) ? 1 : 0, 011 A^B, 100 ~(A|B), 101 A<<B[4:0].
REQ-021 SHALL set flags combinationally:
- zf = (F==0).
- sf = F[31].
- pf = 1 when F[7:0] has an even number of ones.
- cf = carry-out of bit 31 for add; 1 when A<B unsigned for sub and slt; 0 otherwise.
- of = signed overflow for add, sub and slt; 0 otherwise.
REQ-022 SHALL compute next PC with pcp4=pc+4:
- jump: {pcp4[31:28], instr[25:0], 2'b00}.
- else branch&zf: pcp4 + (imm<<2).
- else pcp4.
REQ-023 SHALL register next PC into pc on every rising clk edge when rst=1; all other outputs are combinational from pc, instruction memory, rd1 and rd2.
REQ-024 SHALL let jump take priority over branch when both are asserted.
REQ-025 SHALL wrap all PC arithmetic modulo 2^32.

Reset
REQ-026 SHALL force pc to 0 immediately when rst=0, independent of clk, and hold it at 0 while rst=0.
REQ-027 SHALL leave instruction memory contents unchanged by reset; imem writes remain enabled during reset.
REQ-028 SHALL fetch word 0 in the first cycle after rst deasserts.

Verification
REQ-029 SHALL pass this scenario: load word0=0x20080005 (addi), reset, rd1=3 -> alu_src=1, reg_write=1, wreg=8, alu_result=8, pc 0->4 next edge.
REQ-030 SHALL pass this scenario: R-type sub with rd1=5, rd2=5 -> alu_ctl=110, alu_result=0, zf=1, pf=1, cf=0, of=0.
REQ-031 SHALL pass this scenario: beq at pc=8 with imm=2, rd1=rd2 -> next pc=0x14; with rd1!=rd2 -> next pc=0x0C.
REQ-032 SHALL pass this scenario: j target 0x40 at pc=0x10 -> next pc=0x100 (upper nibble of pc+4 preserved).
REQ-033 SHALL pass this scenario: add with rd1=0x7FFFFFFF, rd2=1 -> alu_result=0x80000000, of=1, sf=1, cf=0; add with rd1=0xFFFFFFFF, rd2=1 -> 0, cf=1, zf=1.
REQ-034 SHALL pass this scenario: assert rst low mid-run at pc=0x1C, between clock edges -> pc=0 without a clock edge; unknown opcode 0x3F -> all controls 0, alu_ctl=010.

Source files
------------

// File: rtl/mips_fetch_exec_unit.sv
// mips_fetch_exec_unit: single-cycle MIPS fetch, decode and ALU with a loadable instruction ROM
module mips_fetch_exec_unit #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [31:0]                   rd1,
  input  logic [31:0]                   rd2,
  output logic [31:0]                   pc,
  output logic [31:0]                   instr,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    wreg,
  output logic [31:0]                   imm,
  output logic                          reg_write,
  output logic                          mem_to_reg,
  output logic                          mem_write,
  output logic                          alu_src,
  output logic                          reg_dst,
  output logic                          branch,
  output logic                          jump,
  output logic [2:0]                    alu_ctl,
  output logic [31:0]                   alu_result,
  output logic                          zf,
  output logic                          cf,
  output logic                          sf,
  output logic                          pf,
  output logic                          of
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [31:0] r_mem [IMEM_DEPTH];
  logic [31:0] r_pc;
  logic [31:0] w_b, w_pcp4, w_npc;
  logic [32:0] w_sum, w_diff;
  logic        w_ov_add, w_ov_sub, w_lt;
  always_ff @(posedge clk)
    if (imem_we) r_mem[imem_waddr] <= imem_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_pc <= '0;
    else      r_pc <= w_npc;
  assign pc    = r_pc;
  assign instr = r_mem[r_pc[AW+1:2]];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign wreg  = reg_dst ? instr[15:11] : instr[20:16];
  assign imm   = {{16{instr[15]}}, instr[15:0]};
  always_comb begin
    {reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump} = '0;
    alu_ctl = 3'b010;
    case (instr[31:26])
      6'b000000: begin
        {reg_write, reg_dst} = 2'b11;
        case (instr[5:0])
          6'b100000: alu_ctl = 3'b010;
          6'b100010: alu_ctl = 3'b110;
          6'b100100: alu_ctl = 3'b000;
          6'b100101: alu_ctl = 3'b001;
          6'b101010: alu_ctl = 3'b111;
          default:   {reg_write, reg_dst} = 2'b00;
        endcase
      end
      6'b100011: {reg_write, alu_src, mem_to_reg} = 3'b111;
      6'b101011: {mem_write, alu_src} = 2'b11;
      6'b000100: begin
        branch  = 1'b1;
        alu_ctl = 3'b110;
      end
      6'b001000: {reg_write, alu_src} = 2'b11;
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end
  // Unsigned borrow sits in w_diff[32]; signed less-than corrects the sign bit by overflow.
  assign w_b      = alu_src ? imm : rd2;
  assign w_sum    = {1'b0, rd1} + {1'b0, w_b};
  assign w_diff   = {1'b0, rd1} - {1'b0, w_b};
  assign w_ov_add = (rd1[31] == w_b[31]) && (w_sum[31] != rd1[31]);
  assign w_ov_sub = (rd1[31] != w_b[31]) && (w_diff[31] != rd1[31]);
  assign w_lt     = w_diff[31] ^ w_ov_sub;
  always_comb begin
    case (alu_ctl)
      3'b000:  alu_result = rd1 & w_b;
      3'b001:  alu_result = rd1 | w_b;
      3'b010:  alu_result = w_sum[31:0];
      3'b011:  alu_result = rd1 ^ w_b;
      3'b100:  alu_result = ~(rd1 | w_b);
      3'b101:  alu_result = rd1 << w_b[4:0];
      3'b110:  alu_result = w_diff[31:0];
      default: alu_result = {31'b0, w_lt};
    endcase
  end
  assign zf = (alu_result == 32'd0);
  assign sf = alu_result[31];
  assign pf = ~^alu_result[7:0];
  assign cf = (alu_ctl == 3'b010) ? w_sum[32] :
              (alu_ctl == 3'b110 || alu_ctl == 3'b111) ? w_diff[32] : 1'b0;
  assign of = (alu_ctl == 3'b010) ? w_ov_add :
              (alu_ctl == 3'b110 || alu_ctl == 3'b111) ? w_ov_sub : 1'b0;
  assign w_pcp4 = r_pc + 32'd4;
  assign w_npc  = jump          ? {w_pcp4[31:28], instr[25:0], 2'b00} :
                  (branch && zf) ? w_pcp4 + {imm[29:0], 2'b00} : w_pcp4;
endmodule

// File: tb/tb_mips_fetch_exec_unit.sv
// tb_mips_fetch_exec_unit: random and directed checks against a behavioural MIPS step model
module tb_mips_fetch_exec_unit;
  localparam int D = 64;
  typedef struct packed {
    logic [6:0]  ctl;
    logic [2:0]  alu;
    logic [31:0] res;
    logic [4:0]  fl;
    logic [4:0]  wreg;
    logic [31:0] npc;
  } exp_t;
  logic        clk, rst, imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata, rd1, rd2, pc, instr, imm, alu_result;
  logic [4:0]  rs, rt, wreg;
  logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump;
  logic [2:0]  alu_ctl;
  logic        zf, cf, sf, pf, of;
  logic [31:0] m_mem [D];
  logic [31:0] m_pc;
  exp_t        t_step;
  int          n_chk = 0, n_fail = 0;

  mips_fetch_exec_unit #(.IMEM_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .rd1(rd1), .rd2(rd2), .pc(pc), .instr(instr), .rs(rs), .rt(rt), .wreg(wreg), .imm(imm),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .branch(branch), .jump(jump), .alu_ctl(alu_ctl), .alu_result(alu_result),
    .zf(zf), .cf(cf), .sf(sf), .pf(pf), .of(of)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [31:0] ins, a, b, p);
    exp_t        e;
    logic [5:0]  op = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] bb, f, p4;
    longint      ua, ub, sa, sb, s;
    logic        c = 0, o = 0;
    e.ctl = 7'b0;
    e.alu = 3'd2;
    if (op == 6'h00) begin
      if (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42) e.ctl = 7'b1000100;
      e.alu = fn == 6'd34 ? 3'd6 : fn == 6'd36 ? 3'd0 : fn == 6'd37 ? 3'd1 : fn == 6'd42 ? 3'd7 : 3'd2;
    end
    else if (op == 6'h23) e.ctl = 7'b1101000;
    else if (op == 6'h2b) e.ctl = 7'b0011000;
    else if (op == 6'h04) begin e.ctl = 7'b0000010; e.alu = 3'd6; end
    else if (op == 6'h08) e.ctl = 7'b1001000;
    else if (op == 6'h02) e.ctl = 7'b0000001;
    bb = e.ctl[3] ? sx : b;
    ua = {32'b0, a};
    ub = {32'b0, bb};
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    case (e.alu)
      3'd0: f = a & bb;
      3'd1: f = a | bb;
      3'd2: begin
        s = ua + ub; f = s[31:0]; c = s > 64'sd4294967295;
        s = sa + sb; o = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      3'd3: f = a ^ bb;
      3'd4: f = ~(a | bb);
      3'd5: f = a << bb[4:0];
      default: begin
        s = sa - sb; o = s > 64'sd2147483647 || s < -64'sd2147483648;
        c = ua < ub;
        f = (e.alu == 3'd6) ? a - bb : (sa < sb ? 32'd1 : 32'd0);
      end
    endcase
    e.res  = f;
    e.fl   = {f == 0, c, f[31], ($countones(f[7:0]) % 2) == 0, o};
    e.wreg = e.ctl[2] ? ins[15:11] : ins[20:16];
    p4     = p + 32'd4;
    e.npc  = e.ctl[0] ? {p4[31:28], ins[25:0], 2'b00} : (e.ctl[1] && f == 0) ? p4 + sx * 4 : p4;
    return e;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m_pc <= 0;
    else begin
      t_step = model(m_mem[m_pc[7:2]], rd1, rd2, m_pc);
      m_pc <= t_step.npc;
    end
  always @(posedge clk)
    if (imem_we) m_mem[imem_waddr] <= imem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ins = m_mem[m_pc[7:2]];
    exp_t e = model(ins, rd1, rd2, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, ins);
    chk("rs", {27'b0, rs}, {27'b0, ins[25:21]});
    chk("rt", {27'b0, rt}, {27'b0, ins[20:16]});
    chk("wreg", {27'b0, wreg}, {27'b0, e.wreg});
    chk("imm", imm, {{16{ins[15]}}, ins[15:0]});
    chk("ctl", {25'b0, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump}, {25'b0, e.ctl});
    chk("alu_ctl", {29'b0, alu_ctl}, {29'b0, e.alu});
    chk("result", alu_result, e.res);
    chk("flags", {27'b0, zf, cf, sf, pf, of}, {27'b0, e.fl});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [31:0] r = $urandom;
    int          k = $urandom_range(0, 11);
    if (k < 5) return {6'h00, r[25:6], fns[k]};
    if (k == 5) return {6'h00, r[25:0]};
    if (k == 6) return {6'h23, r[25:0]};
    if (k == 7) return {6'h2b, r[25:0]};
    if (k == 8) return {6'h04, r[25:0]};
    if (k == 9) return {6'h08, r[25:0]};
    if (k == 10) return {6'h02, r[25:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    int k = $urandom_range(0, 3);
    return k == 0 ? $urandom_range(0, 15) : k == 1 ? 32'h7FFFFFFF + $urandom_range(0, 2) : $urandom;
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1; imem_waddr = a[5:0]; imem_wdata = d;
    @(negedge clk);
    imem_we = 0;
  endtask

  task automatic cur(input logic [31:0] a, input logic [31:0] b);
    rd1 = a; rd2 = b;
    #1 check_all();
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cur(a, b);
  endtask

  task automatic exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    load(0, ins);
    cur(a, b);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 0;
    #1 chk("rst_pc", pc, 0);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1; imem_we = 0; imem_waddr = 0; imem_wdata = 0; rd1 = 0; rd2 = 0;
    #3 rst = 0;
    #1 chk("reset_pc", pc, 0);
    for (int i = 0; i < D; i++) load(i, rand_instr());
    load(1, 32'h0); load(2, 32'h10220002); load(3, 32'h0); load(4, 32'h08000040);
    load(5, 32'h00221822); load(6, 32'h00221820); load(7, 32'h00221824);
    exec(32'h00221822, 5, 5);
    chk("sub_ctl", {29'b0, alu_ctl}, 32'd6);
    chk("sub_res", alu_result, 0);
    chk("sub_flags", {27'b0, zf, cf, sf, pf, of}, 32'b10010);
    exec(32'h00221820, 32'h7FFFFFFF, 1);
    chk("add_ovf_res", alu_result, 32'h80000000);
    chk("add_ovf_flags", {27'b0, zf, cf, sf, pf, of}, 32'b00111);
    exec(32'h00221820, 32'hFFFFFFFF, 1);
    chk("add_carry_res", alu_result, 0);
    chk("add_carry_flags", {27'b0, zf, cf, sf, pf, of}, 32'b11010);
    exec(32'hFC000000, 1, 2);
    chk("bad_op_ctl", {25'b0, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump}, 0);
    chk("bad_op_alu", {29'b0, alu_ctl}, 32'd2);
    for (int i = 0; i < 150; i++) begin
      a = rand_data();
      exec(rand_instr(), a, $urandom_range(0, 3) == 0 ? a : rand_data());
    end
    load(0, 32'h20080005);
    rst = 1;
    cur(3, 0);
    chk("addi_src", {31'b0, alu_src}, 1);
    chk("addi_rw", {31'b0, reg_write}, 1);
    chk("addi_wreg", {27'b0, wreg}, 8);
    chk("addi_res", alu_result, 8);
    step(0, 0);
    chk("pc_after_addi", pc, 4);
    step(7, 7);
    step(0, 0);
    chk("beq_taken_pc", pc, 32'h14);
    rst_pulse();
    cur(3, 0); step(0, 0); step(1, 2); step(0, 0);
    chk("beq_not_taken_pc", pc, 32'h0C);
    step(0, 0);
    chk("j_at_pc", pc, 32'h10);
    step(0, 0);
    chk("j_target_pc", pc, 32'h100);
    load(4, 32'h0);
    rst_pulse();
    cur(3, 0); step(0, 0); step(1, 2);
    for (int i = 0; i < 5; i++) step(1, 2);
    chk("pc_before_async", pc, 32'h1C);
    #2 rst = 0;
    #1 chk("async_rst_pc", pc, 0);
    check_all();
    for (int i = 0; i < D; i++) load(i, rand_instr());
    rst = 1;
    cur(rand_data(), rand_data());
    for (int i = 0; i < 400; i++) begin
      a = rand_data();
      step(a, $urandom_range(0, 2) == 0 ? a : rand_data());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
